// File: rtl/tpu_pkg.sv
// tpu_pkg: shared precision modes, lane-count helper and default accumulator bounds
package tpu_pkg;
  typedef enum logic [1:0] {
    MODE_Q88    = 2'b00,
    MODE_INT16  = 2'b01,
    MODE_INT8X2 = 2'b10,
    MODE_INT4X4 = 2'b11
  } sys_mode_e;

  localparam int ACC_W_DEFAULT = 32;
  localparam logic [ACC_W_DEFAULT-1:0] ACC_MAX = {1'b0, {(ACC_W_DEFAULT-1){1'b1}}};
  localparam logic [ACC_W_DEFAULT-1:0] ACC_MIN = {1'b1, {(ACC_W_DEFAULT-1){1'b0}}};

  function automatic int lanes_for_mode(sys_mode_e m);
    return m == MODE_INT4X4 ? 4 : m == MODE_INT8X2 ? 2 : 1;
  endfunction
endpackage

// File: rtl/pe_mp_alu.sv
// pe_mp_alu: combinational signed lane multiply-sum for full, 2-lane and 4-lane packed operands
module pe_mp_alu
  import tpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum
);
  localparam int H = DATA_W / 2;
  localparam int Q = DATA_W / 4;
  logic signed [2*DATA_W-1:0] w_p1;
  logic signed [DATA_W-1:0]   w_p2 [2];
  logic signed [H-1:0]        w_p4 [4];
  logic signed [ACC_W-1:0]    w_s1, w_s2, w_s4;
  int                         w_lanes;
  // operands are sign-extended to the product width so each product is exact
  assign w_p1 = (2*DATA_W)'($signed(i_a)) * (2*DATA_W)'($signed(i_b));
  for (genvar g = 0; g < 2; g++) begin : g_half
    assign w_p2[g] = DATA_W'($signed(i_a[g*H+:H])) * DATA_W'($signed(i_b[g*H+:H]));
  end
  for (genvar g = 0; g < 4; g++) begin : g_quart
    assign w_p4[g] = H'($signed(i_a[g*Q+:Q])) * H'($signed(i_b[g*Q+:Q]));
  end
  assign w_s1    = ACC_W'(w_p1);
  assign w_s2    = ACC_W'(w_p2[0]) + ACC_W'(w_p2[1]);
  assign w_s4    = ACC_W'(w_p4[0]) + ACC_W'(w_p4[1]) + ACC_W'(w_p4[2]) + ACC_W'(w_p4[3]);
  assign w_lanes = lanes_for_mode(sys_mode_e'(i_mode));
  assign o_sum   = w_lanes == 4 ? w_s4 : w_lanes == 2 ? w_s2 : w_s1;
endmodule

// File: rtl/pe_mp.sv
// pe_mp: multi-precision systolic PE with saturating accumulate and WS/OS dataflow
module pe_mp
  import tpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_enabled,
  input  logic [1:0]        sys_mode,
  input  logic              sat_en,
  input  logic              os_mode,
  input  logic [ACC_W-1:0]  pe_psum_in,
  input  logic [DATA_W-1:0] pe_weight_in,
  input  logic              pe_accept_w_in,
  input  logic [DATA_W-1:0] pe_input_in,
  input  logic              pe_valid_in,
  input  logic              pe_switch_in,
  input  logic              pe_drain_in,
  output logic [ACC_W-1:0]  pe_psum_out,
  output logic [DATA_W-1:0] pe_weight_out,
  output logic [DATA_W-1:0] pe_input_out,
  output logic              pe_valid_out,
  output logic              pe_switch_out,
  output logic              pe_drain_out,
  output logic              pe_ovf
);
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [DATA_W-1:0] r_active, r_inactive;
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] w_weight;
  logic [ACC_W-1:0]  w_alu, w_addend, w_sat;
  logic [ACC_W:0]    w_full;
  logic              w_ov, w_mac;
  assign w_weight = pe_switch_in ? r_inactive : r_active;
  pe_mp_alu #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_alu (
    .i_mode (sys_mode),
    .i_a    (pe_input_in),
    .i_b    (w_weight),
    .o_sum  (w_alu)
  );
  // sat_add: WS adds the incoming psum, OS adds the local accumulator
  assign w_addend = os_mode ? r_acc : pe_psum_in;
  assign w_full   = {w_addend[ACC_W-1], w_addend} + {w_alu[ACC_W-1], w_alu};
  assign w_ov     = w_full[ACC_W] ^ w_full[ACC_W-1];
  assign w_sat    = (w_ov && sat_en) ? (w_full[ACC_W] ? SAT_MIN : SAT_MAX) : w_full[ACC_W-1:0];
  assign w_mac    = pe_valid_in && !(os_mode && pe_drain_in);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active      <= '0;
      r_inactive    <= '0;
      r_acc         <= '0;
      pe_psum_out   <= '0;
      pe_weight_out <= '0;
      pe_input_out  <= '0;
      pe_valid_out  <= 1'b0;
      pe_switch_out <= 1'b0;
      pe_drain_out  <= 1'b0;
      pe_ovf        <= 1'b0;
    end else if (pe_enabled) begin
      pe_valid_out  <= pe_valid_in;
      pe_switch_out <= pe_switch_in;
      pe_drain_out  <= pe_drain_in;
      pe_weight_out <= pe_weight_in;
      if (pe_valid_in) pe_input_out <= pe_input_in;
      if (pe_accept_w_in) r_inactive <= pe_weight_in;
      if (pe_switch_in) r_active <= pe_accept_w_in ? pe_weight_in : r_inactive;
      if (w_mac && w_ov) pe_ovf <= 1'b1;
      pe_psum_out <= os_mode ? (pe_drain_in ? r_acc : '0) : (pe_valid_in ? w_sat : '0);
      if (os_mode) r_acc <= pe_drain_in ? pe_psum_in : (pe_valid_in ? w_sat : r_acc);
    end
  end
endmodule

// File: tb/tb_pe_mp.sv
// tb_pe_mp: directed self-checking bench for pe_mp at DATA_W=16, ACC_W=32
module tb_pe_mp;
  import tpu_pkg::*;
  logic        clk = 1'b0;
  logic        rst, pe_enabled, sat_en, os_mode;
  logic [1:0]  sys_mode;
  logic [31:0] pe_psum_in, pe_psum_out;
  logic [15:0] pe_weight_in, pe_input_in, pe_weight_out, pe_input_out;
  logic        pe_accept_w_in, pe_valid_in, pe_switch_in, pe_drain_in;
  logic        pe_valid_out, pe_switch_out, pe_drain_out, pe_ovf;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pe_mp #(.DATA_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .pe_enabled(pe_enabled), .sys_mode(sys_mode),
    .sat_en(sat_en), .os_mode(os_mode), .pe_psum_in(pe_psum_in),
    .pe_weight_in(pe_weight_in), .pe_accept_w_in(pe_accept_w_in),
    .pe_input_in(pe_input_in), .pe_valid_in(pe_valid_in),
    .pe_switch_in(pe_switch_in), .pe_drain_in(pe_drain_in),
    .pe_psum_out(pe_psum_out), .pe_weight_out(pe_weight_out),
    .pe_input_out(pe_input_out), .pe_valid_out(pe_valid_out),
    .pe_switch_out(pe_switch_out), .pe_drain_out(pe_drain_out), .pe_ovf(pe_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic acc, input logic sw, input logic vld, input logic drn,
                       input logic [15:0] w, input logic [15:0] x, input logic [31:0] p);
    pe_accept_w_in = acc; pe_switch_in = sw; pe_valid_in = vld; pe_drain_in = drn;
    pe_weight_in = w; pe_input_in = x; pe_psum_in = p;
  endtask

  initial begin
    rst = 1'b1; pe_enabled = 1'b1; sat_en = 1'b0; os_mode = 1'b0; sys_mode = MODE_INT16;
    drive(0, 0, 0, 0, 16'h0, 16'h0, 32'h0);
    tick();
    rst = 1'b0;
    // load weight 5 into both registers, then reset
    drive(1, 1, 1, 0, 16'd5, 16'd1, 32'h0);
    tick();
    chk("load_wout", pe_weight_out, 16'd5);
    chk("load_vout", pe_valid_out, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_psum", pe_psum_out, 32'h0);
    chk("rst_wout", pe_weight_out, 16'h0);
    chk("rst_in", pe_input_out, 16'h0);
    chk("rst_vld", pe_valid_out, 1'b0);
    chk("rst_sw", pe_switch_out, 1'b0);
    chk("rst_ovf", pe_ovf, 1'b0);
    drive(0, 0, 1, 0, 16'h0, 16'd2, 32'h0);
    tick();
    chk("rst_active_cleared", pe_psum_out, 32'h0);
    // WS INT16 with same-cycle switch
    drive(1, 0, 0, 0, 16'd3, 16'h0, 32'h0);
    tick();
    drive(0, 1, 1, 0, 16'd3, 16'hFFF9, 32'd100);
    tick();
    chk("ws_switch_psum", pe_psum_out, 32'd79);
    chk("ws_switch_vout", pe_valid_out, 1'b1);
    chk("ws_switch_sout", pe_switch_out, 1'b1);
    chk("ws_switch_in", pe_input_out, 16'hFFF9);
    // clock-enable low holds everything
    pe_enabled = 1'b0;
    drive(1, 0, 1, 1, 16'd9, 16'd5, 32'd0);
    tick();
    chk("hold_psum", pe_psum_out, 32'd79);
    chk("hold_in", pe_input_out, 16'hFFF9);
    chk("hold_wout", pe_weight_out, 16'd3);
    chk("hold_sout", pe_switch_out, 1'b1);
    chk("hold_dout", pe_drain_out, 1'b0);
    pe_enabled = 1'b1;
    // INT8x2: 0x02*0x03 + (-3)*4 = -6
    drive(1, 0, 0, 0, 16'h0304, 16'h0, 32'h0);
    tick();
    sys_mode = MODE_INT8X2;
    drive(0, 1, 1, 0, 16'h0304, 16'h02FD, 32'h0);
    tick();
    chk("int8x2", pe_psum_out, 32'hFFFFFFFA);
    // INT4x4: 1+2+3+4 = 10
    drive(1, 0, 0, 0, 16'h1111, 16'h0, 32'h0);
    tick();
    sys_mode = MODE_INT4X4;
    drive(0, 1, 1, 0, 16'h1111, 16'h1234, 32'h0);
    tick();
    chk("int4x4", pe_psum_out, 32'd10);
    // switch+accept together: product uses old inactive, both regs become 2
    sys_mode = MODE_Q88;
    drive(1, 1, 1, 0, 16'd2, 16'h0010, 32'h0);
    tick();
    chk("sw_acc_old", pe_psum_out, 32'h00011110);
    drive(0, 0, 1, 0, 16'd0, 16'd3, 32'h0);
    tick();
    chk("sw_acc_active", pe_psum_out, 32'd6);
    drive(0, 1, 1, 0, 16'd0, 16'd4, 32'h0);
    tick();
    chk("sw_acc_inactive", pe_psum_out, 32'd8);
    chk("no_ovf_yet", pe_ovf, 1'b0);
    // positive saturation
    sys_mode = MODE_INT16;
    drive(1, 0, 0, 0, 16'h7FFF, 16'h0, 32'h0);
    tick();
    sat_en = 1'b1;
    drive(0, 1, 1, 0, 16'h7FFF, 16'h7FFF, 32'h7FFF0000);
    tick();
    chk("sat_pos", pe_psum_out, ACC_MAX);
    chk("sat_ovf", pe_ovf, 1'b1);
    sat_en = 1'b0;
    drive(0, 0, 1, 0, 16'h7FFF, 16'h7FFF, 32'h7FFF0000);
    tick();
    chk("wrap", pe_psum_out, 32'hBFFE0001);
    drive(0, 0, 1, 0, 16'h7FFF, 16'd1, 32'h0);
    tick();
    chk("clean_mac", pe_psum_out, 32'h00007FFF);
    chk("ovf_sticky", pe_ovf, 1'b1);
    sat_en = 1'b1;
    drive(0, 0, 1, 0, 16'h0, 16'h8000, 32'h80000000);
    tick();
    chk("sat_neg", pe_psum_out, ACC_MIN);
    // weight pass-through without accept
    drive(0, 0, 0, 0, 16'd1, 16'h0, 32'h0);
    tick();
    chk("wpass1", pe_weight_out, 16'd1);
    chk("ws_idle_psum", pe_psum_out, 32'h0);
    drive(0, 0, 0, 0, 16'd2, 16'h0, 32'h0);
    tick();
    chk("wpass2", pe_weight_out, 16'd2);
    drive(0, 0, 0, 0, 16'd3, 16'h0, 32'h0);
    tick();
    chk("wpass3", pe_weight_out, 16'd3);
    drive(0, 0, 1, 0, 16'd0, 16'd1, 32'h0);
    tick();
    chk("wpass_active", pe_psum_out, 32'h00007FFF);
    // OS: 2*3 + 4*3 + (-1)*3 = 15
    drive(1, 0, 0, 0, 16'd3, 16'h0, 32'h0);
    tick();
    os_mode = 1'b1;
    drive(0, 1, 1, 0, 16'd0, 16'd2, 32'h0);
    tick();
    chk("os_mac1", pe_psum_out, 32'h0);
    drive(0, 0, 1, 0, 16'd0, 16'd4, 32'h0);
    tick();
    drive(0, 0, 1, 0, 16'd0, 16'hFFFF, 32'h0);
    tick();
    chk("os_mac3", pe_psum_out, 32'h0);
    drive(0, 0, 0, 0, 16'd0, 16'd0, 32'h0);
    tick();
    chk("os_idle", pe_psum_out, 32'h0);
    drive(0, 0, 0, 1, 16'd0, 16'd0, 32'h0);
    tick();
    chk("os_drain", pe_psum_out, 32'd15);
    chk("os_drain_out", pe_drain_out, 1'b1);
    drive(0, 0, 0, 1, 16'd0, 16'd0, 32'h0);
    tick();
    chk("os_acc_cleared", pe_psum_out, 32'h0);
    // drain with a concurrent MAC discards the MAC
    drive(0, 0, 1, 0, 16'd0, 16'd2, 32'h0);
    tick();
    drive(0, 0, 1, 1, 16'd0, 16'd5, 32'h55);
    tick();
    chk("os_drain_vs_mac", pe_psum_out, 32'd6);
    chk("os_drain_fwd_in", pe_input_out, 16'd5);
    chk("os_drain_fwd_v", pe_valid_out, 1'b1);
    drive(0, 0, 0, 1, 16'd0, 16'd0, 32'h0);
    tick();
    chk("os_chain_in", pe_psum_out, 32'h55);
    // reset wins over a low enable
    pe_enabled = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_over_en_psum", pe_psum_out, 32'h0);
    chk("rst_over_en_ovf", pe_ovf, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
